// File: rtl/vga_line_scheduler.sv
// rtl/vga_line_scheduler.sv - ping-pong line buffer between the pixel producer and the uv_to_vga display path
// One bank fills through a valid/ready handshake while the display reads the other by column.
module vga_line_scheduler #(
   parameter int                LINE_W   = 320,
   parameter int                DATA_W   = 8,
   parameter int                H_SHIFT  = 1,
   parameter logic [DATA_W-1:0] BLANK_UV = 8'h0F
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_last,
   output logic              wr_ready,
   input  logic              rd_en,
   input  logic [9:0]        rd_col,
   output logic [DATA_W-1:0] rd_data,
   input  logic              line_end,
   input  logic              frame_start,
   output logic              underrun,
   output logic [15:0]       underrun_cnt,
   output logic              fill_busy
);

   localparam int PTR_W = $clog2(LINE_W);
   localparam int LEN_W = $clog2(LINE_W + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LINE_W - 1);

   typedef enum logic {ST_FILL, ST_FULL} state_t;

   state_t            state, state_nxt;
   logic              wr_bank;
   logic              rd_bank;
   logic [PTR_W-1:0]  wr_ptr;
   logic [LEN_W-1:0]  len_q [2];
   logic [1:0]        vld;
   logic [DATA_W-1:0] mem [2][LINE_W];

   logic              accept;
   logic              complete;
   logic              do_swap;
   logic              do_underrun;
   logic [9:0]        idx_full;
   logic [15:0]       idx_ext;
   logic [15:0]       len_ext;
   logic              rd_hit;

   // The banks are always distinct, so the read bank is simply the other one.
   assign rd_bank = ~wr_bank;

   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      complete    = 1'b0;
      do_swap     = 1'b0;
      do_underrun = 1'b0;
      if (frame_start) begin
         state_nxt = ST_FILL;
      end else if (state == ST_FILL) begin
         accept   = wr_valid & wr_ready;
         complete = accept & (wr_last | (wr_ptr == PTR_LAST));
         if (complete) begin
            if (line_end) do_swap = 1'b1;
            else          state_nxt = ST_FULL;
         end else if (line_end) begin
            do_underrun = 1'b1;
         end
      end else if (line_end) begin
         do_swap   = 1'b1;
         state_nxt = ST_FILL;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_FILL;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ready     <= 1'b0;
         fill_busy    <= 1'b0;
         underrun     <= 1'b0;
         underrun_cnt <= 16'h0000;
      end else begin
         wr_ready  <= (state_nxt == ST_FILL);
         fill_busy <= (state_nxt == ST_FILL);
         underrun  <= do_underrun;
         if (do_underrun && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'h0001;
      end
   end

   // A completing accept and a swap touch different banks' valid bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_bank  <= 1'b0;
         wr_ptr   <= '0;
         len_q[0] <= '0;
         len_q[1] <= '0;
         vld      <= 2'b00;
      end else if (frame_start) begin
         wr_ptr       <= '0;
         vld[rd_bank] <= 1'b0;
      end else begin
         if (complete) begin
            wr_ptr         <= '0;
            len_q[wr_bank] <= LEN_W'(wr_ptr) + LEN_W'(1);
            vld[wr_bank]   <= 1'b1;
         end else if (accept) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_swap) begin
            wr_bank      <= rd_bank;
            vld[rd_bank] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_bank][wr_ptr] <= wr_data;
   end

   // Compare at full column width so columns past the line read as blank.
   assign idx_full = rd_col >> H_SHIFT;
   assign idx_ext  = 16'(idx_full);
   assign len_ext  = 16'(len_q[rd_bank]);
   assign rd_hit   = rd_en & vld[rd_bank] & (idx_ext < len_ext);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      rd_data <= BLANK_UV;
      else if (rd_hit) rd_data <= mem[rd_bank][idx_full[PTR_W-1:0]];
      else             rd_data <= BLANK_UV;
   end

endmodule

// File: doc/vga_line_scheduler.md
Name: vga_line_scheduler

Overview:
- Ping-pong line-buffer controller between the pixel producer and the uv_to_vga display path.
- The producer fills one bank through a valid/ready handshake while the display reads the other bank by column.
- Banks swap at the display's end-of-line strobe, but only when the fill bank is complete; otherwise the old line is repeated and an underrun is flagged.
- Output rd_data feeds uv_in of uv_to_vga directly.

Parameters:
- LINE_W, 320: pixels stored per line per bank.
- DATA_W, 8: pixel width (uv code: hue[7:4], lum[3:0]).
- H_SHIFT, 1: display column right-shift to get line index (640 cols -> 320 pixels).
- BLANK_UV, 8'h0F: value output when no valid pixel exists.

Ports:
- clk, in, 1: single clock for all logic (display pixel clock domain).
- reset, in, 1: asynchronous, active-low reset.
- wr_valid, in, 1: producer has a pixel.
- wr_data, in, DATA_W: producer pixel.
- wr_last, in, 1: qualifies wr_data as the last pixel of the line.
- wr_ready, out, 1: controller accepts a pixel this cycle.
- rd_en, in, 1: display is in the visible region.
- rd_col, in, 10: display column.
- rd_data, out, DATA_W: pixel for the display, registered.
- line_end, in, 1: one-cycle pulse at the end of each display line.
- frame_start, in, 1: one-cycle pulse at the start of each frame.
- underrun, out, 1: one-cycle pulse when a swap is missed.
- underrun_cnt, out, 16: saturating count of missed swaps.
- fill_busy, out, 1: high in the FILL state.

Behaviour:
- Storage: 2 banks x LINE_W x DATA_W. Each bank has a length register len[b] (0..LINE_W) and a valid bit vld[b].
- Reset (reset=0, asynchronous):
  - wr_bank=0, rd_bank=1, wr_ptr=0, len[*]=0, vld[*]=0, state=FILL.
  - rd_data=BLANK_UV, wr_ready=0, underrun=0, underrun_cnt=0, fill_busy=0.
  - Outputs take their reset values immediately. Bank contents are not cleared.
  - On the first clk edge after deassertion, wr_ready=1 and fill_busy=1 (registered outputs).
- FILL state:
  - wr_ready=1. A pixel is accepted when wr_valid&wr_ready: it is written at mem[wr_bank][wr_ptr] and wr_ptr increments.
  - Line completes on an accept with wr_last=1 or wr_ptr==LINE_W-1. Then len[wr_bank]=wr_ptr+1, vld[wr_bank]=1, wr_ptr=0, next state=FULL.
  - wr_valid without an accept has no effect. There is no write beyond LINE_W-1.
- FULL state:
  - wr_ready=0.
  - On line_end: rd_bank<=wr_bank, wr_bank<=rd_bank, vld[new wr_bank]=0, next state=FILL.
- line_end while in FILL (fill incomplete):
  - No swap. underrun=1 for exactly one cycle.
  - underrun_cnt increments, saturating at 16'hFFFF.
  - The display repeats the current rd_bank. The fill continues uninterrupted.
- line_end in the same cycle as a completing accept: the line completes and the swap happens in that same cycle. Next state=FILL on the swapped bank, no underrun.
- frame_start:
  - wr_ptr=0, state=FILL on the current wr_bank, vld[rd_bank]=0 (display shows blank until the next swap).
  - Any pixel presented that cycle is not written.
  - frame_start beats line_end in the same cycle: no swap, no underrun.
- Read path, 1-cycle latency:
  - idx = rd_col >> H_SHIFT.
  - Next cycle rd_data = mem[rd_bank][idx] if rd_en and vld[rd_bank] and idx < len[rd_bank]; otherwise BLANK_UV.
  - The bank is selected by the rd_bank value before any swap occurring in the same cycle.
  - Reads never stall writes. The two banks are always distinct.
- Widths:
  - wr_ptr and idx are clog2(LINE_W) bits.
  - idx is computed at full 10-bit width before the compare, so out-of-range columns give BLANK_UV.

Test Plan:
- Reset with reset=0 mid-fill (wr_ptr=100) -> rd_data=8'h0F and wr_ready=0 immediately; after release wr_ready=1 and wr_ptr restarts at 0.
- Fill 320 pixels with value=i[7:0], then pulse line_end -> swap. With rd_en=1 and rd_col=10, rd_data=8'h05 one cycle later; rd_col=639 gives 8'h3F.
- Fill 200 pixels with wr_last on pixel 199, then swap -> rd_col=398 gives pixel 199; rd_col=400 gives 8'h0F.
- Pulse line_end after only 50 pixels accepted -> underrun pulses once, underrun_cnt=1, rd_data unchanged from the previous line. Completing the fill then pulsing line_end swaps normally.
- line_end coincident with the 320th accept -> swap the same cycle, no underrun, wr_ready stays 1.
- frame_start and line_end together in FULL -> no swap, no underrun, display outputs 8'h0F. Preload underrun_cnt=16'hFFFF, then force an underrun -> count stays 16'hFFFF.
